// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select encoding and default PC geometry shared across the core
package pc_pkg;
    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JUMP   = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_sel_e;
    localparam int PC_WIDTH = 16;
    localparam int PC_STEP  = 2;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control strobes into and PC/status out of the sequencer
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
) ();
    logic             pc_en;
    logic [2:0]       sel;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] target;
    logic             clear_err;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             ras_empty;
    logic             ras_full;
    logic             err_overflow;
    logic             err_underflow;
    logic             err_illegal;
    modport master (
        output pc_en, sel, offset, target, clear_err,
        input  pc, pc_plus, ras_empty, ras_full, err_overflow, err_underflow, err_illegal
    );
    modport slave (
        input  pc_en, sel, offset, target, clear_err,
        output pc, pc_plus, ras_empty, ras_full, err_overflow, err_underflow, err_illegal
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    top_q, top_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_pop;
    assign empty_o     = cnt_q == '0;
    assign full_o      = cnt_q == (PW+1)'(DEPTH);
    assign do_pop      = pop_i & ~push_i & ~empty_o;
    assign top_data_o  = mem_q[top_q - PW'(1)];
    assign overflow_o  = push_i & full_o;
    assign underflow_o = pop_i & ~push_i & empty_o;
    // pointer wraps freely; count saturates so a full push keeps it at DEPTH
    always_comb begin
        top_d = push_i ? top_q + PW'(1) : do_pop ? top_q - PW'(1) : top_q;
        cnt_d = (push_i & ~full_o) ? cnt_q + (PW+1)'(1) : do_pop ? cnt_q - (PW+1)'(1) : cnt_q;
    end
    // pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end
    // storage is left unreset; a push in a reset cycle is discarded
    always_ff @(posedge clk) begin
        if (push_i && !reset) mem_q[top_q] <= push_data_i;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with inc/branch/jump/call/return and a return-address stack
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                  WIDTH      = PC_WIDTH,
    parameter int                  STEP       = PC_STEP,
    parameter int                  ALIGN_BITS = 1,
    parameter logic [WIDTH-1:0]    RESET_PC   = '0,
    parameter int                  RAS_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;
    logic [WIDTH-1:0] pc_q, pc_d, raw_pc, ras_top;
    logic             load, illegal, push, pop, empty, full, ovf, unf;
    logic             ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
    assign push = bus.pc_en & (bus.sel == PC_CALL);
    assign pop  = bus.pc_en & (bus.sel == PC_RET);
    ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (bus.pc_plus),
        .top_data_o  (ras_top),
        .empty_o     (empty),
        .full_o      (full),
        .overflow_o  (ovf),
        .underflow_o (unf)
    );
    // next-PC mux; only real loads are aligned, and a RET on an empty stack is not a load
    always_comb begin
        raw_pc  = pc_q;
        load    = 1'b1;
        illegal = 1'b0;
        case (bus.sel)
            PC_HOLD:   load = 1'b0;
            PC_INC:    raw_pc = bus.pc_plus;
            PC_BRANCH: raw_pc = pc_q + bus.offset;
            PC_JUMP:   raw_pc = bus.target;
            PC_CALL:   raw_pc = bus.target;
            PC_RET:    begin raw_pc = ras_top; load = ~empty; end
            default:   begin load = 1'b0; illegal = 1'b1; end
        endcase
        pc_d  = (bus.pc_en && load) ? raw_pc & ALIGN_MASK : pc_q;
        ovf_d = ovf | (ovf_q & ~bus.clear_err);
        unf_d = unf | (unf_q & ~bus.clear_err);
        ill_d = (bus.pc_en & illegal) | (ill_q & ~bus.clear_err);
    end
    // PC and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            ill_q <= ill_d;
        end
    end
    assign bus.pc            = pc_q;
    assign bus.pc_plus       = pc_q + STEP_W;
    assign bus.ras_empty     = empty;
    assign bus.ras_full      = full;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;
    assign bus.err_illegal   = ill_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queued scoreboard checked by an independent monitor
module tb_pc_sequencer;
    import pc_pkg::*;
    typedef struct {
        logic [15:0] pc;
        logic [4:0]  flags;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    pc_sequencer_if #(.WIDTH(16)) bus ();
    pc_sequencer #(.WIDTH(16), .STEP(2), .ALIGN_BITS(1), .RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pc", bus.pc, e.pc);
                chk("pc_plus", bus.pc_plus, e.pc + 16'd2);
                chk("flags{empty,full,ovf,unf,ill}",
                    {11'd0, bus.ras_empty, bus.ras_full, bus.err_overflow, bus.err_underflow, bus.err_illegal},
                    {11'd0, e.flags});
            end
        end
    end
    task automatic cyc(input logic r, input logic en, input logic [2:0] s, input logic [15:0] off,
                       input logic [15:0] tgt, input logic clr, input logic [15:0] epc, input logic [4:0] ef);
        exp_t e;
        reset         = r;
        bus.pc_en     = en;
        bus.sel       = s;
        bus.offset    = off;
        bus.target    = tgt;
        bus.clear_err = clr;
        @(posedge clk);
        #1;
        e.pc    = epc;
        e.flags = ef;
        sb.push_back(e);
    endtask
    initial begin
        //  rst en sel        offset    target    clr pc        {empty,full,ovf,unf,ill}
        cyc(1, 0, PC_HOLD,   16'h0000, 16'h0000, 0, 16'h0000, 5'b10000);
        cyc(0, 1, PC_INC,    16'h0000, 16'h0000, 0, 16'h0002, 5'b10000);
        cyc(0, 1, PC_INC,    16'h0000, 16'h0000, 0, 16'h0004, 5'b10000);
        cyc(0, 1, PC_INC,    16'h0000, 16'h0000, 0, 16'h0006, 5'b10000);
        cyc(0, 0, PC_INC,    16'h0000, 16'h0000, 0, 16'h0006, 5'b10000);
        cyc(0, 1, PC_JUMP,   16'h0000, 16'h0010, 0, 16'h0010, 5'b10000);
        cyc(0, 1, PC_BRANCH, 16'hFFFA, 16'h0000, 0, 16'h000A, 5'b10000);
        cyc(0, 1, PC_JUMP,   16'h0000, 16'h1235, 0, 16'h1234, 5'b10000);
        cyc(0, 1, PC_JUMP,   16'h0000, 16'hFFFE, 0, 16'hFFFE, 5'b10000);
        cyc(0, 1, PC_INC,    16'h0000, 16'h0000, 0, 16'h0000, 5'b10000);
        cyc(0, 1, PC_JUMP,   16'h0000, 16'h0100, 0, 16'h0100, 5'b10000);
        cyc(0, 1, PC_CALL,   16'h0000, 16'h0200, 0, 16'h0200, 5'b00000);
        cyc(0, 1, PC_CALL,   16'h0000, 16'h0300, 0, 16'h0300, 5'b00000);
        cyc(0, 1, PC_CALL,   16'h0000, 16'h0400, 0, 16'h0400, 5'b00000);
        cyc(0, 1, PC_CALL,   16'h0000, 16'h0500, 0, 16'h0500, 5'b01000);
        cyc(0, 1, PC_CALL,   16'h0000, 16'h0600, 0, 16'h0600, 5'b01100);
        cyc(0, 1, PC_RET,    16'h0000, 16'h0000, 0, 16'h0502, 5'b00100);
        cyc(0, 1, PC_RET,    16'h0000, 16'h0000, 0, 16'h0402, 5'b00100);
        cyc(0, 1, PC_RET,    16'h0000, 16'h0000, 0, 16'h0302, 5'b00100);
        cyc(0, 1, PC_RET,    16'h0000, 16'h0000, 0, 16'h0202, 5'b10100);
        cyc(0, 0, PC_HOLD,   16'h0000, 16'h0000, 1, 16'h0202, 5'b10000);
        cyc(0, 1, PC_JUMP,   16'h0000, 16'h0020, 0, 16'h0020, 5'b10000);
        cyc(0, 1, PC_RET,    16'h0000, 16'h0000, 0, 16'h0020, 5'b10010);
        cyc(0, 0, PC_HOLD,   16'h0000, 16'h0000, 1, 16'h0020, 5'b10000);
        cyc(0, 1, PC_RET,    16'h0000, 16'h0000, 1, 16'h0020, 5'b10010);
        cyc(0, 0, PC_HOLD,   16'h0000, 16'h0000, 1, 16'h0020, 5'b10000);
        cyc(0, 1, 3'd7,      16'h0000, 16'h4444, 0, 16'h0020, 5'b10001);
        cyc(0, 0, PC_HOLD,   16'h0000, 16'h0000, 1, 16'h0020, 5'b10000);
        cyc(0, 0, 3'd7,      16'h0000, 16'h4444, 0, 16'h0020, 5'b10000);
        cyc(0, 1, PC_JUMP,   16'h0000, 16'h0700, 0, 16'h0700, 5'b10000);
        cyc(0, 1, PC_CALL,   16'h0000, 16'h0800, 0, 16'h0800, 5'b00000);
        cyc(0, 1, PC_RET,    16'h0000, 16'h0000, 0, 16'h0702, 5'b10000);
        cyc(0, 1, 3'd6,      16'h0000, 16'h0000, 0, 16'h0702, 5'b10001);
        cyc(0, 1, PC_CALL,   16'h0000, 16'h0900, 0, 16'h0900, 5'b00001);
        cyc(0, 1, PC_CALL,   16'h0000, 16'h0A00, 0, 16'h0A00, 5'b00001);
        cyc(1, 1, PC_CALL,   16'h0000, 16'h0B00, 0, 16'h0000, 5'b10000);
        cyc(0, 1, PC_RET,    16'h0000, 16'h0000, 0, 16'h0000, 5'b10010);
        cyc(0, 1, PC_BRANCH, 16'h0005, 16'h0000, 0, 16'h0004, 5'b10010);
        cyc(0, 1, PC_HOLD,   16'h0000, 16'h1111, 0, 16'h0004, 5'b10010);
        bus.pc_en = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the multicycle core. It replaces the fixed +2 incrementer with a registered PC.
- The PC is updated only on a strobe from the control FSM. It supports hold, increment, relative branch, absolute jump, call and return.
- A small circular return-address stack (RAS) holds call return addresses.
- Feeds instruction-memory address and the PC+STEP link value to the datapath.

Parameters:
- WIDTH, 16, PC / address width in bits
- STEP, 2, byte increment per sequential instruction (power of two)
- ALIGN_BITS, 1, low PC bits forced to 0 on every load (log2 of STEP)
- RESET_PC, 16'h0000, PC value after reset
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc_en  in  1  update strobe from control FSM; PC/RAS change only when high
- sel  in  3  next-PC mode: 0 HOLD, 1 INC, 2 BRANCH, 3 JUMP, 4 CALL, 5 RET, 6-7 reserved
- offset  in  WIDTH  signed two's-complement branch displacement, in bytes
- target  in  WIDTH  absolute jump/call destination
- clear_err  in  1  clears sticky error flags
- pc  out  WIDTH  current PC (registered)
- pc_plus  out  WIDTH  pc + STEP (combinational, mod 2^WIDTH)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH
- err_overflow  out  1  sticky: CALL issued while full
- err_underflow  out  1  sticky: RET issued while empty
- err_illegal  out  1  sticky: reserved sel value used with pc_en

Behaviour:
- Reset (sync, has priority over everything):
  - pc = RESET_PC, RAS count = 0, top pointer = 0, all err_* = 0.
  - RAS storage is not reset.
  - Reset asserted mid-sequence discards any in-flight update in that cycle.
- pc_en = 0: pc, RAS and flags hold; sel, offset and target are ignored. clear_err is still honoured.
- All arithmetic is unsigned mod 2^WIDTH; wrap-around is silent, with no flag.
- On every PC load, the low ALIGN_BITS bits are forced to 0.
- Update latency: with pc_en = 1 at edge N, the new pc is visible after edge N; pc_plus follows in the same cycle.
- Modes with pc_en = 1:
  - HOLD: pc unchanged.
  - INC: pc <= pc + STEP.
  - BRANCH: pc <= pc + offset.
  - JUMP: pc <= target.
  - CALL: push pc + STEP onto the RAS; pc <= target.
  - RET: pop the RAS top; pc <= popped value.
  - Reserved (6, 7): pc unchanged, err_illegal <= 1.
- RAS organisation:
  - Circular buffer. The top pointer increments on push and decrements on pop, mod RAS_DEPTH.
  - count saturates at 0 and RAS_DEPTH.
- CALL while full:
  - Push still occurs and overwrites the oldest entry; pc <= target; count stays RAS_DEPTH.
  - err_overflow <= 1.
- RET while empty:
  - pc unchanged; pointer and count unchanged.
  - err_underflow <= 1.
- CALL followed directly by RET returns exactly the pushed pc + STEP. There is no bypass hazard because both are registered.
- Error flags:
  - Sticky until reset or clear_err = 1.
  - If clear_err and a new error occur in the same cycle, the new error wins (flag = 1).
- ras_empty and ras_full are derived from the registered count; no combinational path from sel.

Decomposition:
- Shared package (pc_pkg):
  - sel encoding constants (PC_HOLD, PC_INC, PC_BRANCH, PC_JUMP, PC_CALL, PC_RET).
  - Default WIDTH and STEP constants, shared with the control FSM and the instruction-memory interface.
- One natural sub-module: ras_stack.
  - Parametrised circular LIFO with push/pop, push_data, top_data, empty, full and overflow/underflow strobes.
  - pc_sequencer instantiates it and owns the PC register, next-PC mux and sticky flags.

Test Plan (WIDTH=16, STEP=2, RAS_DEPTH=4):
- Reset, then 3 cycles pc_en=1 sel=INC -> pc 0000, 0002, 0004, 0006; pc_plus = pc+2 each cycle. A cycle with pc_en=0 holds pc at 0006.
- pc=0010, BRANCH offset=FFFA -> pc=000A. Then JUMP target=1235 -> pc=1234 (LSB cleared). pc=FFFE, INC -> pc=0000, no flag.
- Nested calls:
  - From pc=0100: CALL 0200, CALL 0300, CALL 0400, CALL 0500 -> ras_full=1.
  - 5th CALL 0600 from pc=0500 -> err_overflow=1, pc=0600.
  - Four RETs -> pc 0502, 0402, 0302, 0202, then ras_empty=1.
- RET with empty RAS at pc=0020 -> pc stays 0020, err_underflow=1. clear_err pulse -> flag 0. clear_err with a simultaneous empty RET -> flag stays 1.
- sel=7 with pc_en=1 -> pc unchanged, err_illegal=1. sel=7 with pc_en=0 -> no flag.
- Reset mid-stream:
  - After two CALLs, assert reset in the same cycle as a CALL -> pc=0000, ras_empty=1, all flags 0.
  - Subsequent RET -> err_underflow=1.
